dvbc_diff_enc_mc: RTL and testbench

- Next-generation DVB-C QAM differential encoder for the two MSBs of each symbol (Annex A rotation-invariant coding).
- Generalised to NUM_CH time-interleaved channels, each with its own differential state.
- Mode is latched per channel at frame start. Invalid modes are flagged.
- Upstream and downstream use a ready/valid handshake with a 2-entry skid buffer. Sits between byte-to-m-tuple conversion and the QAM mapper.

---
 rtl/dvbc_diff_enc_mc.sv | 180 ++++++++++++++++++
 tb/tb_dvbc_diff_enc_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvbc_diff_enc_mc.sv
// Multi-channel DVB-C differential encoder for the two MSBs of each m-tuple, with a 2-entry output skid buffer.
// Optional macro DIFFENC_STATS_EN adds saturating output-symbol and error counters.
module dvbc_diff_enc_mc #(
   parameter int WIDTH  = 12,
   parameter int NUM_CH = 4,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [WIDTH-1:0] iData,
   input  logic [CH_W-1:0]  iCh,
   input  logic             iSof,
   input  logic [3:0]       iMode,
   input  logic             iValid,
   output logic             oReady,
   output logic [WIDTH-1:0] oData,
   output logic [CH_W-1:0]  oCh,
   output logic             oErr,
   output logic             oValid,
   input  logic             iReady
`ifdef DIFFENC_STATS_EN
   ,
   output logic [31:0]      oSymCnt,
   output logic [15:0]      oErrCnt
`endif
);

   localparam logic [3:0] DEF_MODE = (WIDTH < 8) ? 4'(WIDTH) : 4'd8;

   logic [3:0]       mode_q [NUM_CH];
   logic [3:0]       mode_d [NUM_CH];
   logic [NUM_CH-1:0] ip_q, ip_d, qp_q, qp_d;
   logic [WIDTH-1:0] dat_q [2];
   logic [WIDTH-1:0] dat_d [2];
   logic [CH_W-1:0]  ch_q [2];
   logic [CH_W-1:0]  ch_d [2];
   logic [1:0]       err_q, err_d;
   logic             wp_q, wp_d, rp_q, rp_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             rdy_q, rdy_d;

   logic             acc, pop;
   logic [3:0]       cur_mode, sel_mode, sh_amt;
   logic             cur_ip, cur_qp, ip, qp, ak, bk, ik, qk, m_ok;
   logic [WIDTH-1:0] sh, mask, enc;

   assign acc    = iValid && oReady;
   assign pop    = oValid && iReady;
   assign oValid = (cnt_q != 2'd0);
   assign oData  = dat_q[rp_q];
   assign oCh    = ch_q[rp_q];
   assign oErr   = err_q[rp_q];
   // The stored ready flag resets to 1; masking with iRst keeps it low while reset is held.
   assign oReady = rdy_q && !iRst;

   always_comb begin
      cur_mode = DEF_MODE;
      cur_ip   = 1'b0;
      cur_qp   = 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (iCh == CH_W'(c)) begin
            cur_mode = mode_q[c];
            cur_ip   = ip_q[c];
            cur_qp   = qp_q[c];
         end
      end
      sel_mode = iSof ? iMode : cur_mode;
      ip       = iSof ? 1'b0 : cur_ip;
      qp       = iSof ? 1'b0 : cur_qp;
      m_ok     = (sel_mode >= 4'd4) && (sel_mode <= 4'd8) && (int'(sel_mode) <= WIDTH);
      sh_amt   = sel_mode - 4'd2;
      sh       = iData >> sh_amt;
      ak       = sh[1];
      bk       = sh[0];
      if (ak == bk) begin
         ik = ak ^ ip;
         qk = bk ^ qp;
      end else begin
         ik = ak ^ qp;
         qk = bk ^ ip;
      end
      mask = WIDTH'(2'b11) << sh_amt;
      enc  = m_ok ? ((iData & ~mask) | (WIDTH'({ik, qk}) << sh_amt)) : iData;
   end

   always_comb begin
      mode_d = mode_q;
      ip_d   = ip_q;
      qp_d   = qp_q;
      dat_d  = dat_q;
      ch_d   = ch_q;
      err_d  = err_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      if (acc) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (iCh == CH_W'(c)) begin
               if (iSof) begin
                  mode_d[c] = iMode;
                  ip_d[c]   = 1'b0;
                  qp_d[c]   = 1'b0;
               end
               if (m_ok) begin
                  ip_d[c] = ik;
                  qp_d[c] = qk;
               end
            end
         end
         dat_d[wp_q] = enc;
         ch_d[wp_q]  = iCh;
         err_d[wp_q] = !m_ok;
         wp_d        = !wp_q;
      end
      if (pop) begin
         rp_d = !rp_q;
      end
      cnt_d = cnt_q + {1'b0, acc} - {1'b0, pop};
      rdy_d = (cnt_d <= 2'd1);
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            mode_q[c] <= DEF_MODE;
         end
         ip_q  <= '0;
         qp_q  <= '0;
         for (int unsigned e = 0; e < 2; e++) begin
            dat_q[e] <= '0;
            ch_q[e]  <= '0;
         end
         err_q <= '0;
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= '0;
         rdy_q <= 1'b1;
      end else begin
         mode_q <= mode_d;
         ip_q   <= ip_d;
         qp_q   <= qp_d;
         dat_q  <= dat_d;
         ch_q   <= ch_d;
         err_q  <= err_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         rdy_q  <= rdy_d;
      end
   end

`ifdef DIFFENC_STATS_EN
   logic [31:0] sym_cnt_q, sym_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      sym_cnt_d = sym_cnt_q;
      err_cnt_d = err_cnt_q;
      if (pop && (sym_cnt_q != '1)) begin
         sym_cnt_d = sym_cnt_q + 32'd1;
      end
      if (pop && oErr && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         sym_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         sym_cnt_q <= sym_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign oSymCnt = sym_cnt_q;
   assign oErrCnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dvbc_diff_enc_mc.sv
// Bench for dvbc_diff_enc_mc: directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_dvbc_diff_enc_mc;

   localparam int WIDTH  = 12;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   logic             iClk = 1'b0;
   logic             iRst;
   logic [WIDTH-1:0] iData;
   logic [CH_W-1:0]  iCh;
   logic             iSof;
   logic [3:0]       iMode;
   logic             iValid;
   logic             oReady;
   logic [WIDTH-1:0] oData;
   logic [CH_W-1:0]  oCh;
   logic             oErr;
   logic             oValid;
   logic             iReady;

`ifdef DIFFENC_STATS_EN
   logic [31:0] oSymCnt;
   logic [15:0] oErrCnt;
`endif

   dvbc_diff_enc_mc #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .iData  (iData),
      .iCh    (iCh),
      .iSof   (iSof),
      .iMode  (iMode),
      .iValid (iValid),
      .oReady (oReady),
      .oData  (oData),
      .oCh    (oCh),
      .oErr   (oErr),
      .oValid (oValid),
      .iReady (iReady)
`ifdef DIFFENC_STATS_EN
      ,
      .oSymCnt(oSymCnt),
      .oErrCnt(oErrCnt)
`endif
   );

   always #5 iClk = ~iClk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model: per-channel (I,Q) state and latched mode, FIFO of expected outputs.
   typedef struct {
      int d;
      int c;
      int e;
   } exp_t;

   exp_t exp_q[$];
   int   obs_q[$];
   int   mode_m[NUM_CH];
   int   ip_m[NUM_CH];
   int   qp_m[NUM_CH];

   function automatic int def_mode();
      return (WIDTH < 8) ? WIDTH : 8;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      for (int c = 0; c < NUM_CH; c++) begin
         mode_m[c] = def_mode();
         ip_m[c]   = 0;
         qp_m[c]   = 0;
      end
   endtask

   task automatic model_step(input int ch, input int sof, input int mode, input int data);
      int m, ipv, qpv, a, b, i_k, q_k;
      exp_t e;
      m   = sof ? mode : mode_m[ch];
      ipv = sof ? 0 : ip_m[ch];
      qpv = sof ? 0 : qp_m[ch];
      if (sof) begin
         mode_m[ch] = mode;
         ip_m[ch]   = 0;
         qp_m[ch]   = 0;
      end
      e.c = ch;
      if (m >= 4 && m <= 8 && m <= WIDTH) begin
         a = (data / (1 << (m - 1))) % 2;
         b = (data / (1 << (m - 2))) % 2;
         if (a == b) begin
            i_k = a ^ ipv;
            q_k = b ^ qpv;
         end else begin
            i_k = a ^ qpv;
            q_k = b ^ ipv;
         end
         e.d = data - ((data / (1 << (m - 2))) % 4) * (1 << (m - 2)) + (2 * i_k + q_k) * (1 << (m - 2));
         e.e = 0;
         ip_m[ch] = i_k;
         qp_m[ch] = q_k;
      end else begin
         e.d = data;
         e.e = 1;
      end
      exp_q.push_back(e);
   endtask

   // Transfers are resolved at the falling edge, where inputs and outputs are stable.
   always @(negedge iClk) begin
      exp_t e;
      if (iRst) begin
         model_reset();
      end else begin
         if (oValid && iReady) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("out_data", oData, e.d);
               check("out_ch", oCh, e.c);
               check("out_err", oErr, e.e);
               obs_q.push_back(int'(oErr) * 65536 + int'(oData));
            end
         end
         if (iValid && oReady) begin
            model_step(int'(iCh), int'(iSof), int'(iMode), int'(iData));
         end
      end
   end

   task automatic send(input int ch, input int sof, input int mode, input int data);
      bit ok;
      int n;
      iValid = 1'b1;
      iCh    = CH_W'(ch);
      iSof   = sof[0];
      iMode  = 4'(mode);
      iData  = WIDTH'(data);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
         @(negedge iClk);
         ok = oReady;
         @(posedge iClk);
         #1;
         n++;
      end
      iValid = 1'b0;
      iSof   = 1'b0;
      check("send_accept", ok, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || oValid) && n < 100) begin
         @(posedge iClk);
         n++;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic check_obs(input string tag, input int e[$]);
      check($sformatf("%s_count", tag), obs_q.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         if (i < obs_q.size()) check($sformatf("%s_%0d", tag, i), obs_q[i], e[i]);
      end
      obs_q.delete();
   endtask

   initial begin
      int e[$];
      logic [WIDTH-1:0] hold;

      iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
      iData = '0; iCh = '0; iSof = 1'b0; iMode = 4'd0;
      repeat (3) @(posedge iClk);
      #1;
      check("rst_ready", oReady, 0);
      check("rst_valid", oValid, 0);
      check("rst_data", oData, 0);
      check("rst_err", oErr, 0);
      check("rst_ch", oCh, 0);
      iRst = 1'b0;
      #1;
      check("post_rst_ready", oReady, 1);
      @(posedge iClk);
      #1;

      // Single channel, mode 4, one-cycle latency.
      send(0, 1, 4, 'h8);
      check("latency_valid", oValid, 1);
      check("latency_data", oData, 'h8);
      send(0, 0, 4, 'h8);
      send(0, 0, 4, 'h8);
      drain();
      e = '{'h8, 'hC, 'h4};
      check_obs("mode4_seq", e);

      // Equal MSBs from state (1,0).
      send(0, 1, 4, 'h8);
      send(0, 0, 4, 'h0);
      send(0, 0, 4, 'h0);
      drain();
      e = '{'h8, 'h8, 'h8};
      check_obs("equal_bits", e);

      // Two interleaved channels, mode 6, back-to-back.
      for (int k = 0; k < 5; k++) begin
         send(0, (k == 0), 6, 'h20);
         send(1, (k == 0), 6, 'h20);
      end
      drain();
      e = '{'h20, 'h20, 'h30, 'h30, 'h10, 'h10, 'h00, 'h00, 'h20, 'h20};
      check_obs("interleave", e);

      // Invalid mode passes data and flags error; a later valid frame recovers.
      send(1, 1, 9, 'h234);
      send(1, 0, 4, 'h8);
      send(1, 1, 4, 'h8);
      drain();
      e = '{'h10234, 'h10008, 'h8};
      check_obs("bad_mode", e);

      // Stall: two accepted, third blocked, outputs held.
      iReady = 1'b0;
      send(2, 1, 4, 'h8);
      send(2, 0, 4, 'h8);
      check("stall_ready_fall", oReady, 0);
      hold = oData;
      iValid = 1'b1; iCh = 2'd2; iSof = 1'b0; iMode = 4'd4; iData = 'h8;
      for (int k = 0; k < 3; k++) begin
         @(posedge iClk);
         #1;
         check("stall_ready", oReady, 0);
         check("stall_hold", oData, hold);
         check("stall_valid", oValid, 1);
      end
      iReady = 1'b1;
      send(2, 0, 4, 'h8);
      drain();
      e = '{'h8, 'hC, 'h4};
      check_obs("stall_order", e);

      // Reset with two symbols buffered.
      iReady = 1'b0;
      send(3, 1, 6, 'h20);
      send(3, 0, 6, 'h20);
      iRst = 1'b1;
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      #1;
      check("midrst_valid", oValid, 0);
      check("midrst_ready", oReady, 1);
      iReady = 1'b1;
      send(0, 0, 4, 'h008);
      drain();
      e = '{'h008};
      check_obs("midrst_mode8", e);

      // Random traffic with random back-pressure.
      for (int k = 0; k < 600; k++) begin
         iValid = ($urandom_range(0, 1) == 1);
         iCh    = CH_W'($urandom_range(0, NUM_CH - 1));
         iSof   = ($urandom_range(0, 7) == 0);
         iMode  = 4'($urandom_range(3, 9));
         iData  = WIDTH'($urandom);
         iReady = ($urandom_range(0, 3) != 0);
         @(posedge iClk);
         #1;
      end
      iValid = 1'b0;
      iReady = 1'b1;
      drain();
      obs_q.delete();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
